// File: rtl/neuron_13in_bwd.sv
// Gradient-descent update for the 13-input sigmoid neuron: one shared multiplier, done 17 clocks after start.
// start is taken only in IDLE; a start that arrives while busy is dropped, and w_out/bias_out hold their values between updates.
module neuron_13in_bwd #(
  parameter int N_IN = 13,
  parameter int DW   = 17,
  parameter int FRAC = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DW*N_IN-1:0] x_in,
  input  logic [DW*N_IN-1:0] w_in,
  input  logic [DW-1:0]      bias_in,
  input  logic [DW-1:0]      y_in,
  input  logic [DW-1:0]      target,
  input  logic [DW-1:0]      lr,
  output logic [DW*N_IN-1:0] w_out,
  output logic [DW-1:0]      bias_out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {IDLE, DERIV, DELTA, SCALE, UPD, BIAS} state_t;

  localparam logic [3:0]             LAST = 4'(N_IN - 1);
  localparam logic signed [DW+1:0]   ONE  = (DW+2)'(2**FRAC);
  localparam logic signed [DW+2:0]   MAXV = {3'b000, {DW{1'b1}}};

  state_t state, state_nx;
  logic [3:0] idx;

  logic [DW-1:0] x_r  [N_IN];
  logic [DW-1:0] w_r  [N_IN];
  logic [DW-1:0] wo_r [N_IN];
  logic [DW-1:0] bias_r, y_r, t_r, lr_r, deriv, bias_o;
  logic signed [DW:0] err, delta, g;
  logic done_r;

  logic signed [DW+1:0]   op_a, op_b;
  logic signed [2*DW+3:0] prod, shifted;
  logic signed [DW+2:0]   upd_sum, bias_sum;
  logic                   unused_bits;

  function automatic logic [DW-1:0] sat(input logic signed [DW+2:0] v);
    if (v[DW+2]) return '0;
    else if (v > MAXV) return '1;
    else return v[DW-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = DERIV;
      DERIV:   state_nx = DELTA;
      DELTA:   state_nx = SCALE;
      SCALE:   state_nx = UPD;
      UPD:     if (idx == LAST) state_nx = BIAS;
      BIAS:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand select for the single time-shared multiplier.
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state)
      DERIV: begin op_a = $signed({2'b00, y_r});  op_b = ONE - $signed({2'b00, y_r}); end
      DELTA: begin op_a = {err[DW], err};         op_b = $signed({2'b00, deriv});    end
      SCALE: begin op_a = {delta[DW], delta};     op_b = $signed({2'b00, lr_r});     end
      UPD:   begin op_a = {g[DW], g};             op_b = $signed({2'b00, x_r[idx]}); end
      default: ;
    endcase
  end

  assign prod     = op_a * op_b;
  assign shifted  = prod >>> FRAC;
  assign upd_sum  = $signed({3'b000, w_r[idx]}) + $signed({shifted[DW+1], shifted[DW+1:0]});
  assign bias_sum = $signed({3'b000, bias_r}) + $signed({{2{g[DW]}}, g});
  assign unused_bits = ^shifted[2*DW+3:DW+2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) begin
        x_r[i]  <= '0;
        w_r[i]  <= '0;
        wo_r[i] <= '0;
      end
      bias_r <= '0; y_r <= '0; t_r <= '0; lr_r <= '0;
      deriv  <= '0; err <= '0; delta <= '0; g <= '0;
      bias_o <= '0; idx <= '0; done_r <= 1'b0;
    end else begin
      done_r <= (state == BIAS);
      case (state)
        IDLE: if (start) begin
          for (int i = 0; i < N_IN; i++) begin
            x_r[i] <= x_in[DW*i +: DW];
            w_r[i] <= w_in[DW*i +: DW];
          end
          bias_r <= bias_in;
          y_r    <= y_in;
          t_r    <= target;
          lr_r   <= lr;
        end
        DERIV: begin
          err   <= $signed({1'b0, t_r}) - $signed({1'b0, y_r});
          deriv <= shifted[DW-1:0];
        end
        DELTA: delta <= shifted[DW:0];
        SCALE: g <= shifted[DW:0];
        UPD: begin
          wo_r[idx] <= sat(upd_sum);
          idx       <= (idx == LAST) ? '0 : idx + 4'd1;
        end
        BIAS: bias_o <= sat(bias_sum);
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < N_IN; i++) begin : g_pack
    assign w_out[DW*i +: DW] = wo_r[i];
  end

  assign bias_out = bias_o;
  assign busy     = (state != IDLE);
  assign done     = done_r;

endmodule

// File: tb/tb_neuron_13in_bwd.sv
// Scoreboard bench for neuron_13in_bwd: directed updates with hand-computed results, checked whenever done pulses.
module tb_neuron_13in_bwd;

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [220:0] x_in, w_in, w_out;
  logic [16:0]  bias_in, y_in, target, lr, bias_out;
  logic         busy, done;

  neuron_13in_bwd dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x_in(x_in), .w_in(w_in), .bias_in(bias_in),
    .y_in(y_in), .target(target), .lr(lr),
    .w_out(w_out), .bias_out(bias_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [220:0] w;
    logic [16:0]  b;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [220:0] rep(input logic [16:0] v);
    return {13{v}};
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending update (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        for (int i = 0; i < 13; i++)
          chk($sformatf("w_out[%0d]", i), int'(w_out[17*i +: 17]), int'(e.w[17*i +: 17]));
        chk("bias_out", int'(bias_out), int'(e.b));
      end
    end
  end

  task automatic set_in(input logic [220:0] x, input logic [220:0] w, input logic [16:0] b,
                        input logic [16:0] y, input logic [16:0] t, input logic [16:0] l);
    x_in = x; w_in = w; bias_in = b; y_in = y; target = t; lr = l;
  endtask

  task automatic go(input logic [220:0] ew, input logic [16:0] eb, output int acc);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    acc = cyc + 1;
    e.w = ew; e.b = eb; e.cyc = acc + 17;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bool_wait: begin
      for (int k = 0; k < 80; k++) begin
        @(negedge clk);
        #1;
        if (!busy && sb.size() == 0) disable bool_wait;
      end
      chk("idle_timeout", 0, 1);
    end
  endtask

  task automatic wait_cyc(input int target_cyc);
    while (cyc < target_cyc) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  logic [220:0] xv, wv, ewv;
  int acc, n;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    set_in('0, '0, '0, '0, '0, '0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_w_out_nonzero", int'(w_out != '0), 0);
    chk("rst_bias_out", int'(bias_out), 0);
    rst_n = 1'b1;

    // Zero error: weights and bias unchanged, busy for 17 cycles.
    set_in(rep(17'd12345), rep(17'd1000), 17'd50, 17'd70000, 17'd70000, 17'd65536);
    go(rep(17'd1000), 17'd50, acc);
    set_in('0, '0, '0, '0, '0, '0);
    n = 0;
    for (int k = 0; k < 40 && busy; k++) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("busy_len", n, 17);
    wait_idle();

    // Positive step: g = 8191, each weight gains 8190.
    set_in(rep(17'd131071), rep(17'd1000), 17'd0, 17'd65536, 17'd131071, 17'd65536);
    go(rep(17'd9190), 17'd8191, acc);
    wait_idle();

    // Negative step with clamping at zero.
    set_in(rep(17'd131071), {{12{17'd20000}}, 17'd5000}, 17'd100, 17'd65536, 17'd0, 17'd65536);
    go({{12{17'd11808}}, 17'd0}, 17'd0, acc);
    wait_idle();

    // Clamping at the top.
    set_in(rep(17'd131071), rep(17'd130000), 17'd0, 17'd65536, 17'd131071, 17'd65536);
    go(rep(17'd131071), 17'd8191, acc);
    wait_idle();

    // x_3 = 0 leaves w_3 untouched.
    xv = rep(17'd131071); xv[51 +: 17] = 17'd0;
    wv = rep(17'd1000);   wv[51 +: 17] = 17'd130000;
    ewv = rep(17'd9190);  ewv[51 +: 17] = 17'd130000;
    set_in(xv, wv, 17'd0, 17'd65536, 17'd131071, 17'd65536);
    go(ewv, 17'd8191, acc);
    wait_idle();

    // start pulses while busy are ignored; changed inputs after capture have no effect.
    set_in(rep(17'd131071), rep(17'd1000), 17'd0, 17'd65536, 17'd131071, 17'd65536);
    go(rep(17'd9190), 17'd8191, acc);
    set_in(rep(17'd7), rep(17'd7), 17'd7, 17'd7, 17'd0, 17'd7);
    wait_cyc(acc + 5); start = 1'b1; @(negedge clk); start = 1'b0;
    wait_cyc(acc + 10); start = 1'b1; @(negedge clk); start = 1'b0;
    wait_idle();
    repeat (25) @(negedge clk);

    // start held high: back-to-back updates every 18 clocks.
    set_in(rep(17'd131071), rep(17'd1000), 17'd0, 17'd65536, 17'd131071, 17'd65536);
    @(negedge clk);
    start = 1'b1;
    acc = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e.w = rep(17'd9190); e.b = 17'd8191; e.cyc = acc + 17 + 18 * k;
      sb.push_back(e);
    end
    wait_cyc(acc + 36);
    start = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);

    // Reset in the middle of the weight loop clears everything at once.
    set_in(rep(17'd131071), rep(17'd1000), 17'd0, 17'd65536, 17'd131071, 17'd65536);
    go(rep(17'd9190), 17'd8191, acc);
    wait_cyc(acc + 9);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    for (int i = 0; i < 13; i++)
      chk($sformatf("midrst_w_out[%0d]", i), int'(w_out[17*i +: 17]), 0);
    chk("midrst_bias_out", int'(bias_out), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Fresh update after reset.
    set_in(rep(17'd131071), {{12{17'd20000}}, 17'd5000}, 17'd100, 17'd65536, 17'd0, 17'd65536);
    go({{12{17'd11808}}, 17'd0}, 17'd0, acc);
    wait_idle();

    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
